pipe_tracker: RTL
=================

PIPE_TRACKER -- requirements
Module: pipe_tracker

Interface
REQ-001 Parameter TICK_DIV, 4, clk cycles per game tick (>=2).
REQ-002 Parameter GRID_W, 16, playfield columns.
REQ-003 Parameter GRID_H, 16, playfield rows; row 0 is the ground.
REQ-004 Parameter BIRD_COL, 3, fixed bird column (1..GRID_W-2).
REQ-005 Parameter GAP, 3, pipe gap height in rows.
REQ-006 clk  input  1  clock; all logic on posedge clk.
REQ-007 reset  input  1  reset, synchronous, active-high.
REQ-008 start  input  1  level; begins a game from IDLE.
REQ-009 bird_row  input  $clog2(GRID_H)  current bird row.
REQ-010 gap_row  input  $clog2(GRID_H)  requested gap bottom row for the next pipe (from external LFSR).
REQ-011 cycle  output  1  one-clk game-tick pulse; drives the score counter's cycle input.
REQ-012 pass  output  1  one-clk pulse, only coincident with cycle, bird cleared a pipe.
REQ-013 lose  output  1  sticky collision flag.
REQ-014 pipe_col  output  $clog2(GRID_W)  current pipe column.
REQ-015 gap_top  output  $clog2(GRID_H)  latched gap bottom row of the current pipe.

Function
REQ-016 FSM states IDLE, RUN, LOST; IDLE->RUN when start=1; RUN->LOST on collision; LOST exits only via reset; start ignored outside IDLE.
REQ-017 Tick counter runs only in RUN, counts 0..TICK_DIV-1, asserts cycle for exactly one clk when at TICK_DIV-1, then wraps to 0.
REQ-018 First cycle pulse in RUN occurs TICK_DIV clks after the IDLE->RUN transition clk.
REQ-019 All evaluation uses pipe_col, gap_top, bird_row sampled on the tick clk (cycle=1).
REQ-020 Ground collision: bird_row==0 on a tick -> lose=1 next clk, state LOST; takes priority over pass.
REQ-021 Pipe check at tick with pipe_col==BIRD_COL: gap_top <= bird_row <= gap_top+GAP-1 -> pass=1 same clk as cycle; otherwise lose=1 next clk.
REQ-022 pass and a lose-causing event never coincide; pass is registered-combinational with cycle, never asserted outside RUN.
REQ-023 On each tick with no collision pipe_col decrements by 1; at pipe_col==0 it reloads GRID_W-1 and gap_top latches the clamped gap_row.
REQ-024 Clamp: gap_row > GRID_H-GAP latches GRID_H-GAP; else gap_row unchanged.
REQ-025 In LOST: cycle=0, pass=0, lose=1, pipe_col and gap_top frozen.
REQ-026 Exactly one pass per pipe crossing; no pass while pipe_col != BIRD_COL.

Reset
REQ-027 Reset dominates all inputs in any state including mid-tick: state IDLE, tick counter 0, cycle=0, pass=0, lose=0, pipe_col=GRID_W-1, gap_top=0.
REQ-028 IDLE->RUN latches clamped gap_row into gap_top.

Configuration
REQ-029 Macro PIPE_SPEEDUP_EN defined: tick period starts at TICK_DIV and halves after every 8th pass, floor 2; a 4-bit pass counter and period register are added, both cleared by reset.
REQ-030 Macro undefined: tick period fixed at TICK_DIV; no pass counter or period register exists.

Structure
REQ-031 Package flappy_pkg holds the state enum (IDLE, RUN, LOST) and default grid constants (GRID_W, GRID_H, BIRD_COL, GAP).
REQ-032 Sub-module tick_gen (counter, period input, enable, cycle output) is instantiated once; FSM, pipe, and collision logic live in pipe_tracker.

Verification (TICK_DIV=4, GRID_W=16, GRID_H=16, BIRD_COL=3, GAP=3)
REQ-033 reset, start=1, gap_row=7, bird_row=8 -> cycle every 4 clks, pipe_col 15..3, pass=1 with the 13th cycle, lose stays 0.
REQ-034 gap_row=7, bird_row=2 -> at tick with pipe_col==3 pass=0, next clk lose=1; cycle stops; pipe_col frozen at 3.
REQ-035 bird_row=0 at any tick, including pipe_col==3 with gap_row=0 -> lose=1, pass=0.
REQ-036 gap_row=15 -> gap_top=13; bird_row=15 passes; after pipe_col 0 tick, pipe_col=15 and gap_top reloads from new gap_row=5.
REQ-037 reset asserted mid-RUN between ticks -> next clk IDLE, all outputs at reset values; cycle absent until start reasserted.
REQ-038 With PIPE_SPEEDUP_EN, 8 passes -> tick period 2 clks, further passes keep period at 2; without macro period stays 4.

Source files
------------

// File: rtl/flappy_pkg.sv
// Shared types and default playfield geometry for the pipe tracker game logic.
package flappy_pkg;

  // Game state: waiting for start, playing, or crashed (left only by reset).
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    LOST = 2'd2
  } state_t;

  // Default geometry and timing.
  localparam int unsigned DFLT_TICK_DIV = 4;
  localparam int unsigned DFLT_GRID_W   = 16;
  localparam int unsigned DFLT_GRID_H   = 16;
  localparam int unsigned DFLT_BIRD_COL = 3;
  localparam int unsigned DFLT_GAP      = 3;

endpackage

// File: rtl/tick_gen.sv
// Game tick generator: counts 0..period-1 while enabled and flags the last count
// with a one-clk cycle pulse. The count is held at 0 whenever the generator is disabled.
module tick_gen #(
  parameter int unsigned PW = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  input  logic [PW-1:0] period,
  output logic          cycle
);

  logic [PW-1:0] cnt_q;
  logic          at_end;

  // A >= compare keeps the counter safe if the period shrinks mid-count.
  assign at_end = (cnt_q >= (period - PW'(1)));
  assign cycle  = enable && at_end;

  // Tick counter: wraps at the end of the period, parks at 0 when disabled.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (!enable) begin
      cnt_q <= '0;
    end else if (at_end) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + PW'(1);
    end
  end

endmodule

// File: rtl/pipe_tracker.sv
// Pipe tracker: game FSM, scrolling pipe, and bird/pipe/ground collision logic.
// Optional feature macro: PIPE_SPEEDUP_EN -- when defined, the tick period starts at
// TICK_DIV and halves after every 8th pass, never dropping below 2 clks.
module pipe_tracker
  import flappy_pkg::*;
#(
  parameter int unsigned TICK_DIV = DFLT_TICK_DIV,
  parameter int unsigned GRID_W   = DFLT_GRID_W,
  parameter int unsigned GRID_H   = DFLT_GRID_H,
  parameter int unsigned BIRD_COL = DFLT_BIRD_COL,
  parameter int unsigned GAP      = DFLT_GAP
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [$clog2(GRID_H)-1:0] bird_row,
  input  logic [$clog2(GRID_H)-1:0] gap_row,
  output logic                      cycle,
  output logic                      pass,
  output logic                      lose,
  output logic [$clog2(GRID_W)-1:0] pipe_col,
  output logic [$clog2(GRID_H)-1:0] gap_top
);

  localparam int unsigned CW = $clog2(GRID_W);
  localparam int unsigned RW = $clog2(GRID_H);
  localparam int unsigned PW = $clog2(TICK_DIV) + 1;

  localparam logic [RW-1:0] GAP_MAX  = RW'(GRID_H - GAP);
  localparam logic [CW-1:0] COL_LAST = CW'(GRID_W - 1);
  localparam logic [CW-1:0] COL_BIRD = CW'(BIRD_COL);

  state_t        state_q, state_d;
  logic [CW-1:0] pipe_col_q, pipe_col_d;
  logic [RW-1:0] gap_top_q, gap_top_d;
  logic [RW-1:0] gap_clamped;
  logic [RW:0]   gap_hi;
  logic [PW-1:0] period;
  logic          run_en;
  logic          ground;
  logic          at_bird;
  logic          in_gap;
  logic          crash;

  // Reset gates the tick enable so no tick can escape during a reset clk.
  assign run_en = (state_q == RUN) && !reset;

  tick_gen #(
    .PW (PW)
  ) u_tick_gen (
    .clk    (clk),
    .reset  (reset),
    .enable (run_en),
    .period (period),
    .cycle  (cycle)
  );

`ifdef PIPE_SPEEDUP_EN
  logic [3:0]    pass_cnt_q;
  logic [PW-1:0] period_q;

  // Speed-up: every 8th pass halves the tick period, floored at 2 clks.
  always_ff @(posedge clk) begin
    if (reset) begin
      pass_cnt_q <= 4'd0;
      period_q   <= PW'(TICK_DIV);
    end else if (pass) begin
      if (pass_cnt_q == 4'd7) begin
        pass_cnt_q <= 4'd0;
        period_q   <= (period_q >= PW'(4)) ? (period_q >> 1) : PW'(2);
      end else begin
        pass_cnt_q <= pass_cnt_q + 4'd1;
      end
    end
  end

  assign period = period_q;
`else
  assign period = PW'(TICK_DIV);
`endif

  // Clamp and gap-window evaluation on the current pipe and bird position.
  always_comb begin
    gap_clamped = (gap_row > GAP_MAX) ? GAP_MAX : gap_row;
    gap_hi      = {1'b0, gap_top_q} + (RW + 1)'(GAP - 1);
    ground      = (bird_row == '0);
    at_bird     = (pipe_col_q == COL_BIRD);
    in_gap      = (bird_row >= gap_top_q) && ({1'b0, bird_row} <= gap_hi);
    // Ground hit wins over a pass through the gap.
    crash       = cycle && (ground || (at_bird && !in_gap));
  end

  assign pass = cycle && at_bird && in_gap && !ground;

  // Game FSM next state: start only matters in IDLE, LOST is left only by reset.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (crash) state_d = LOST;
      LOST:    state_d = LOST;
      default: state_d = IDLE;
    endcase
  end

  // Pipe scroll: one column per clean tick, reload and new gap after column 0.
  always_comb begin
    pipe_col_d = pipe_col_q;
    gap_top_d  = gap_top_q;
    if ((state_q == IDLE) && start) begin
      gap_top_d = gap_clamped;
    end else if (cycle && !crash) begin
      if (pipe_col_q == '0) begin
        pipe_col_d = COL_LAST;
        gap_top_d  = gap_clamped;
      end else begin
        pipe_col_d = pipe_col_q - CW'(1);
      end
    end
  end

  // State and pipe registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      pipe_col_q <= COL_LAST;
      gap_top_q  <= '0;
    end else begin
      state_q    <= state_d;
      pipe_col_q <= pipe_col_d;
      gap_top_q  <= gap_top_d;
    end
  end

  assign lose     = (state_q == LOST);
  assign pipe_col = pipe_col_q;
  assign gap_top  = gap_top_q;

endmodule
